// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
//   Shared types for the control-code issue path.
//   CODE_W       : width of one control code (bit0 -> x0 ... bit6 -> x6)
//   CTRL_REP_W   : default repeat-count width
//   ctrl_entry_t : one buffered code plus its extra-repeat count
//   seq_state_t  : output sequencer states
// ---------------------------------------------------------------------------
package ctrl_pkg;

   localparam int CODE_W     = 7;
   localparam int CTRL_REP_W = 4;

   typedef struct packed {
      logic [CODE_W-1:0]     code;
      logic [CTRL_REP_W-1:0] rep;
   } ctrl_entry_t;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      REPEAT = 2'd1,
      HOLD   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/ctrl_code_fifo.sv
// ---------------------------------------------------------------------------
// ctrl_code_fifo
//   DEPTH x WIDTH synchronous FIFO with flush and an explicit occupancy count.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     flush             : synchronous clear; overrides push and pop
//     push, wr_data     : write request and data (ignored when full)
//     pop               : read request (ignored when empty)
//     rd_data           : head entry, valid whenever !empty
//     full, empty       : status
//     level             : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module ctrl_code_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [LVL_W-1:0] LVL_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push_en, pop_en;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem[rd_ptr_q];

   assign push_en = push && !full  && !flush;
   assign pop_en  = pop  && !empty && !flush;

   // Pointers wrap naturally at PTR_W bits; occupancy is tracked separately
   // so full and empty never need a pointer-compare trick.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which is what keeps latches from being inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push_en && !pop_en)      level_d = level_q + LVL_ONE;
         else if (pop_en && !push_en) level_d = level_q - LVL_ONE;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge values of the others, matching real hardware.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: the storage array has no reset; entries are only ever read after
   // being written, and leaving them unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/ctrl_code_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_code_sequencer
//   Buffers 7-bit control codes tagged with a repeat count and issues each
//   code (rep+1) times over a valid/ready interface feeding decoder x0..x6.
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     flush                    : drop buffered entries and the current issue
//     in_valid/in_ready        : producer handshake (in_ready = !full)
//     in_code, in_rep          : code and extra repetitions
//     code_valid/code_ready    : decoder-side handshake
//     code, code_last          : registered code; last repetition flag
//     level                    : FIFO occupancy (output register excluded)
//     issue_cnt                : accepted issues, wraps
// ---------------------------------------------------------------------------
module ctrl_code_sequencer
   import ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int REP_W = CTRL_REP_W,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CODE_W-1:0]      in_code,
   input  logic [REP_W-1:0]       in_rep,
   output logic                   code_valid,
   input  logic                   code_ready,
   output logic [CODE_W-1:0]      code,
   output logic                   code_last,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       issue_cnt
);

   // Same layout as ctrl_entry_t, sized by this instance's REP_W.
   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [REP_W-1:0]  rep;
   } entry_t;

   localparam logic [REP_W-1:0] REP_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   entry_t     wr_entry, head;
   logic       fifo_full, fifo_empty;
   logic       accept, load;

   seq_state_t        state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              code_valid_q, code_valid_d;
   logic              code_last_q, code_last_d;
   logic [REP_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;

   assign wr_entry = '{code: in_code, rep: in_rep};

   ctrl_code_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .push    (in_valid),
      .wr_data (wr_entry),
      .pop     (load),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign in_ready   = !fifo_full;
   assign accept     = code_valid_q && code_ready;
   assign code_valid = code_valid_q;
   assign code       = code_q;
   assign code_last  = code_last_q;
   assign issue_cnt  = issue_cnt_q;

   always_comb begin
      state_d      = state_q;
      code_d       = code_q;
      code_valid_d = code_valid_q;
      code_last_d  = code_last_q;
      rem_d        = rem_q;
      load         = 1'b0;

      // Counts the accept even on a flush edge: that issue really happened.
      issue_cnt_d  = accept ? issue_cnt_q + CNT_ONE : issue_cnt_q;

      if (flush) begin
         state_d      = EMPTY;
         code_valid_d = 1'b0;
         code_last_d  = 1'b0;
         rem_d        = '0;
      end else begin
         unique case (state_q)
            EMPTY:  load = !fifo_empty;
            REPEAT: begin
               if (accept) begin
                  rem_d       = rem_q - REP_ONE;
                  code_last_d = (rem_q == REP_ONE);
                  if (rem_q == REP_ONE) state_d = HOLD;
               end
            end
            HOLD: begin
               if (accept) begin
                  if (!fifo_empty) begin
                     load = 1'b1;   // back-to-back, no bubble
                  end else begin
                     state_d      = EMPTY;
                     code_valid_d = 1'b0;
                     code_last_d  = 1'b0;
                  end
               end
            end
            default: state_d = EMPTY;
         endcase

         if (load) begin
            code_d       = head.code;
            rem_d        = head.rep;
            code_last_d  = (head.rep == '0);
            code_valid_d = 1'b1;
            state_d      = (head.rep == '0) ? HOLD : REPEAT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         code_last_q  <= 1'b0;
         rem_q        <= '0;
         issue_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         code_last_q  <= code_last_d;
         rem_q        <= rem_d;
         issue_cnt_q  <= issue_cnt_d;
      end
   end

endmodule

// File: tb/tb_ctrl_code_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_code_sequencer
//   Directed stimulus with a scoreboard queue of expected {code, last} issues;
//   a negedge monitor pops and compares on every accepted issue.
// ---------------------------------------------------------------------------
module tb_ctrl_code_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_code;
   logic [3:0] in_rep;
   logic       code_valid;
   logic       code_ready;
   logic [6:0] code;
   logic       code_last;
   logic [2:0] level;
   logic [15:0] issue_cnt;

   ctrl_code_sequencer #(
      .DEPTH (4),
      .REP_W (4),
      .CNT_W (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_rep     (in_rep),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code       (code),
      .code_last  (code_last),
      .level      (level),
      .issue_cnt  (issue_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] code;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
   endtask

   // Expected issues of one entry: rep+1 copies, last only on the final one.
   task automatic expect_entry(input logic [6:0] c, input logic [3:0] r);
      for (int i = 0; i <= int'(r); i++) exp_q.push_back('{code: c, last: (i == int'(r))});
   endtask

   // Monitor: every accepted issue must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && code_valid && code_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_issue: got code 0x%0h, expected no issue at %0t", code, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("issue_code", {25'd0, code}, {25'd0, mon_e.code});
            check("issue_last", {31'd0, code_last}, {31'd0, mon_e.last});
         end
      end
   end

   // Drive one entry; returns #1 after the accepting edge.
   task automatic push(input logic [6:0] c, input logic [3:0] r, input bit track);
      int t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) bound_fail("push_in_ready");
      if (track) expect_entry(c, r);
      in_valid = 1'b1;
      in_code  = c;
      in_rep   = r;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      bit done = 1'b0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !code_valid) done = 1'b1;
      end
      if (!done) bound_fail("drain");
      @(posedge clk); #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      in_code    = '0;
      in_rep     = '0;
      code_ready = 1'b0;
      cycles(2);
      rst = 1'b0;
      cycles(1);

      // ---- 1: reset mid-stream, then single rep=0 issue ----
      push(7'h33, 4'd5, 1'b0);
      push(7'h44, 4'd0, 1'b0);
      @(posedge clk); #3;
      rst = 1'b1;
      #2;
      check("rst_async_valid", {31'd0, code_valid}, 32'd0);
      check("rst_async_level", {29'd0, level}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_code", {25'd0, code}, 32'd0);
      check("rst_last", {31'd0, code_last}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_issue_cnt", {16'd0, issue_cnt}, 32'd0);
      code_ready = 1'b1;
      push(7'h15, 4'd0, 1'b1);
      check("t1_no_bypass", {31'd0, code_valid}, 32'd0);
      check("t1_level", {29'd0, level}, 32'd1);
      @(posedge clk); #1;
      check("t1_valid", {31'd0, code_valid}, 32'd1);
      check("t1_code", {25'd0, code}, 32'h15);
      check("t1_last", {31'd0, code_last}, 32'd1);
      @(posedge clk); #1;
      check("t1_issue_cnt", {16'd0, issue_cnt}, 32'd1);
      check("t1_empty_after", {31'd0, code_valid}, 32'd0);

      // ---- 2: rep=3 -> four issues, last on the fourth ----
      push(7'h7F, 4'd3, 1'b1);
      wait_drain(20);
      check("t2_issue_cnt", {16'd0, issue_cnt}, 32'd5);

      // ---- 3: fill while stalled, then drain back-to-back ----
      code_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push(7'(i), 4'd0, 1'b1);
      check("t3_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_level", {29'd0, level}, 32'd4);
      code_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_no_bubble", {31'd0, code_valid}, 32'd1);
      end
      wait_drain(20);
      check("t3_issue_cnt", {16'd0, issue_cnt}, 32'd10);

      // ---- 4: stall on 0x2A rep=2 ----
      code_ready = 1'b0;
      push(7'h2A, 4'd2, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check("t4_stall_valid", {31'd0, code_valid}, 32'd1);
         check("t4_stall_code", {25'd0, code}, 32'h2A);
         check("t4_stall_last", {31'd0, code_last}, 32'd0);
         @(posedge clk); #1;
      end
      code_ready = 1'b1;
      wait_drain(20);
      check("t4_issue_cnt", {16'd0, issue_cnt}, 32'd13);
      check("t4_empty", {31'd0, code_valid}, 32'd0);

      // ---- 5: flush during REPEAT with level=3, concurrent push and accept ----
      code_ready = 1'b0;
      push(7'h0A, 4'd3, 1'b0);
      push(7'h0B, 4'd0, 1'b0);
      push(7'h0C, 4'd0, 1'b0);
      push(7'h0D, 4'd0, 1'b0);
      check("t5_level_pre", {29'd0, level}, 32'd3);
      exp_q.push_back('{code: 7'h0A, last: 1'b0});
      flush      = 1'b1;
      in_valid   = 1'b1;
      in_code    = 7'h55;
      in_rep     = 4'd0;
      code_ready = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("t5_valid", {31'd0, code_valid}, 32'd0);
      check("t5_level", {29'd0, level}, 32'd0);
      check("t5_last", {31'd0, code_last}, 32'd0);
      check("t5_issue_cnt", {16'd0, issue_cnt}, 32'd14);
      cycles(5);
      check("t5_still_empty", {31'd0, code_valid}, 32'd0);
      check("t5_sb_empty", exp_q.size(), 32'd0);

      // ---- 6: count up to 0xFFFF, then wrap (rep=15 gives 16 issues) ----
      for (int i = 0; i < 4095; i++) push(7'(i), 4'd15, 1'b1);
      push(7'h66, 4'd0, 1'b1);
      wait_drain(400);
      check("t6_cnt_max", {16'd0, issue_cnt}, 32'h0000FFFF);
      push(7'h0C, 4'd0, 1'b1);
      wait_drain(20);
      check("t6_cnt_wrap", {16'd0, issue_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
